piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter for the BasicCPU I/O path.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out on a single line as a framed serial stream: start bit, data LSB-first, stop bit.
- Serves as the transmitting end for the CPU's serial peripheral link. Built from registered state only; no latches.

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_serializer_bit_timer.sv | 45 ++++
 rtl/piso_serializer.sv | 151 +++++++++++++++
 tb/tb_piso_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the piso_serializer transmitter: the FSM state
// encoding and the serial line levels used when framing a word.
// No ports (package).
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Free-running bit-period counter for the serializer. Counts
// 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset
//   clear - hold the counter at 0 (used while the line is idle)
//   tick  - high on the last cycle of each bit period
// ---------------------------------------------------------------------------
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Wrapping on tick keeps the counter aligned to bit boundaries, so every
  // state change (which only happens on tick or out of IDLE) restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on a
// load/ready handshake and sends it as start bit, data LSB-first, stop bit,
// each held CLKS_PER_BIT cycles.
// Optional feature: define PISO_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-low reset
//   data_in - parallel word, sampled only when accepted
//   load    - word valid; accepted when load && ready
//   ready   - high only while idle
//   tx_out  - serial line, idles high
//   busy    - high from acceptance until the frame completes
//   done    - one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    bitIdx_q, bitIdx_d;
  logic             tick;
  logic             timerClear;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Timer is parked in IDLE so the START bit gets a full period from acceptance.
  assign timerClear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timerClear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    tx_out   = LINE_IDLE;
    ready    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (load) begin
          shift_d  = data_in;
          bitIdx_d = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^data_in;
`endif
          state_d  = START;
        end
      end

      START: begin
        tx_out = START_LVL;
        if (tick) begin
          bitIdx_d = '0;
          state_d  = DATA;
        end
      end

      // The current data bit always sits in shift_q[0]; the shift happens at
      // the end of each bit period so the next bit lines up for the next one.
      DATA: begin
        tx_out = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == IW'(WIDTH - 1)) begin
            bitIdx_d = '0;
`ifdef PISO_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        tx_out = parity_q;
        if (tick) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        tx_out = STOP_LVL;
        if (tick) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Self-checking bench for piso_serializer (WIDTH=8, CLKS_PER_BIT=4).
// A frame-level model predicts every output each cycle; directed sequences
// pin the model with hand-computed frames; a random phase stresses it.
// Honours PISO_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = W + 2 + PAR;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         load    = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready;
  logic         tx_out;
  logic         busy;
  logic         done;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  piso_serializer #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Frame-level model: either idle, or some number of cycles into a frame
  // carrying a latched word.
  bit           mBusy = 1'b0;
  int           mK    = 0;
  logic [W-1:0] mWord = '0;

  always @(posedge clk) begin
    if (!reset) begin
      mBusy <= 1'b0;
      mK    <= 0;
    end else if (!mBusy) begin
      if (load) begin
        mBusy <= 1'b1;
        mK    <= 0;
        mWord <= data_in;
      end
    end else if (mK == FRAME_CYC - 1) begin
      mBusy <= 1'b0;
      mK    <= 0;
    end else begin
      mK <= mK + 1;
    end
  end

  function automatic logic expTx();
    int b;
    if (!mBusy) return 1'b1;
    b = mK / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return mWord[b-1];
    if (PAR == 1 && b == W + 1) return ^mWord;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic [W-1:0] d);
    @(posedge clk);
    #2;
    reset   = r;
    load    = l;
    data_in = d;
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("tx_out", {31'd0, tx_out}, {31'd0, expTx()});
      checkOutput("ready",  {31'd0, ready},  {31'd0, !mBusy});
      checkOutput("busy",   {31'd0, busy},   {31'd0, mBusy});
      checkOutput("done",   {31'd0, done},   {31'd0, (mBusy && mK == FRAME_CYC - 1)});
    end
  end

  // Sends one word from idle and samples each bit mid-period.
  task automatic captureFrame(input logic [W-1:0] word, input bit inject,
                              output logic [FRAME_BITS-1:0] bits, output int busyCnt,
                              output int doneCnt, output int doneAt, output int readyAfter);
    busyCnt = 0; doneCnt = 0; doneAt = 0; readyAfter = 0; bits = '0;
    applyStimulus(1'b1, 1'b1, word);
    applyStimulus(1'b1, 1'b0, '0);
    for (int c = 1; c <= FRAME_CYC + 4; c++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin doneCnt++; doneAt = c; end
      if ((c - 1) % CPB == 1 && (c - 1) / CPB < FRAME_BITS) bits[(c - 1) / CPB] = tx_out;
      if (c == FRAME_CYC + 1) readyAfter = int'(ready);
      if (inject && c == 20) begin load = 1'b1; data_in = '1; end
      if (inject && c == 24) load = 1'b0;
    end
  endtask

  logic [FRAME_BITS-1:0] bits;
  logic [FRAME_BITS-1:0] expA5, exp3C;
  int busyCnt, doneCnt, doneAt, readyAfter;
  int gap, f1Ones, f2Ones, c2;

  initial begin
`ifdef PISO_PARITY_EN
    expA5 = 11'b10101001010;
    exp3C = 11'b10001111000;
`else
    expA5 = 10'b1101001010;
    exp3C = 10'b1001111000;
`endif
    // Reset held with load asserted: line must stay idle.
    reset = 1'b0; load = 1'b1; data_in = 8'hFF;
    @(posedge clk);
    #1 checkEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_tx",    {31'd0, tx_out}, 32'd1);
      checkOutput("rst_ready", {31'd0, ready},  32'd1);
      checkOutput("rst_busy",  {31'd0, busy},   32'd0);
      checkOutput("rst_done",  {31'd0, done},   32'd0);
    end
    repeat (3) applyStimulus(1'b1, 1'b0, '0);

    // Single A5 frame with a load attempt mid-frame that must be ignored.
    captureFrame(8'hA5, 1'b1, bits, busyCnt, doneCnt, doneAt, readyAfter);
    checkOutput("a5_bits",  {{(32-FRAME_BITS){1'b0}}, bits}, {{(32-FRAME_BITS){1'b0}}, expA5});
    checkOutput("a5_busy",  busyCnt, FRAME_CYC);
    checkOutput("a5_done",  doneCnt, 1);
    checkOutput("a5_doneAt", doneAt, FRAME_CYC);
    checkOutput("a5_ready", readyAfter, 1);

    // Back-to-back 00 then FF with load held high.
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    gap = 0; f1Ones = 0; f2Ones = 0; doneCnt = 0;
    for (int c = 1; c <= 2 * FRAME_CYC + 4; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
      if (!busy && tx_out && c <= FRAME_CYC + 2) gap++;
      if ((c - 2) % CPB == 0 && (c - 2) / CPB >= 1 && (c - 2) / CPB <= W) f1Ones += int'(tx_out);
      c2 = c - (FRAME_CYC + 1);
      if (c2 >= 2 && (c2 - 2) % CPB == 0 && (c2 - 2) / CPB >= 1 && (c2 - 2) / CPB <= W)
        f2Ones += int'(tx_out);
      if (c == FRAME_CYC + 5) load = 1'b0;
    end
    checkOutput("b2b_done", doneCnt, 2);
    checkOutput("b2b_gap",  gap, 1);
    checkOutput("b2b_f1",   f1Ones, 0);
    checkOutput("b2b_f2",   f2Ones, W);

    // Reset in the middle of data bit 3.
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b0, '0);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_tx",    {31'd0, tx_out}, 32'd1);
    checkOutput("mid_busy",  {31'd0, busy},   32'd0);
    checkOutput("mid_ready", {31'd0, ready},  32'd1);
    checkOutput("mid_done",  {31'd0, done},   32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    captureFrame(8'h3C, 1'b0, bits, busyCnt, doneCnt, doneAt, readyAfter);
    checkOutput("3c_bits", {{(32-FRAME_BITS){1'b0}}, bits}, {{(32-FRAME_BITS){1'b0}}, exp3C});
    checkOutput("3c_done", doneCnt, 1);

`ifdef PISO_PARITY_EN
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    captureFrame(8'h01, 1'b0, bits, busyCnt, doneCnt, doneAt, readyAfter);
    checkOutput("p01_bits", {{(32-FRAME_BITS){1'b0}}, bits}, {21'd0, 11'b11000000010});
    checkOutput("p01_busy", busyCnt, 44);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), W'($urandom));
    end
    repeat (2) applyStimulus(1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
